wb_arbiter: RTL and testbench

Writeback arbiter and register scoreboard for the integer register file. It shares the register file's single write port between the ALU writeback path (source A) and the load-unit writeback path (source B) using valid/ready handshakes. It drives the registered write port one cycle after a handshake. It also tracks which architectural registers have a write in flight, so the issue stage can stall on read-after-write hazards.

---
 rtl/wb_arbiter.sv | 111 +++++++++++
 tb/tb_wb_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: shares the register-file write port between ALU and load
// writeback, and tracks in-flight destination registers for issue stalls.
module wb_arbiter #(
  parameter int XLEN         = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [4:0]      a_rd_addr,
  input  logic [XLEN-1:0] a_rd_data,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [4:0]      b_rd_addr,
  input  logic [XLEN-1:0] b_rd_data,
  output logic            rd_write,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] rd_data,
  input  logic            issue_set,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      chk_rs1,
  input  logic [4:0]      chk_rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            any_busy
);

  logic [3:0]  starve;
  logic        b_pri;
  logic        a_fire;
  logic        b_fire;
  logic [31:0] busy;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;

  assign b_pri = (starve == 4'(STARVE_LIMIT));

  // Grants stay low in reset so upstream sees no transfer.
  assign b_ready = rst_n && b_valid && (b_pri || !a_valid);
  assign a_ready = rst_n && a_valid && !(b_pri && b_valid);

  assign a_fire = a_valid && a_ready;
  assign b_fire = b_valid && b_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve <= 4'd0;
    end else if (b_fire) begin
      starve <= 4'd0;
    end else if (b_valid && !b_pri) begin
      starve <= starve + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_write <= 1'b0;
      rd_addr  <= 5'd0;
      rd_data  <= '0;
    end else begin
      unique case (1'b1)
        a_fire: begin
          rd_write <= (a_rd_addr != 5'd0);
          rd_addr  <= a_rd_addr;
          rd_data  <= a_rd_data;
        end
        b_fire: begin
          rd_write <= (b_rd_addr != 5'd0);
          rd_addr  <= b_rd_addr;
          rd_data  <= b_rd_data;
        end
        default: rd_write <= 1'b0;
      endcase
    end
  end

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_set) set_mask[issue_rd] = 1'b1;
    if (rd_write)  clr_mask[rd_addr]  = 1'b1;
    set_mask[0] = 1'b0;
  end

  // Set is applied after clear so a same-edge reissue keeps the bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~clr_mask) | set_mask;
    end
  end

  assign rs1_busy = busy[chk_rs1];
  assign rs2_busy = busy[chk_rs2];
  assign any_busy = |busy;

  a_no_waw: assert property (@(posedge clk) disable iff (!rst_n)
    (issue_set && issue_rd != 5'd0) |->
      (!busy[issue_rd] || (rd_write && rd_addr == issue_rd)));

  a_wb_a_busy: assert property (@(posedge clk) disable iff (!rst_n)
    (a_fire && a_rd_addr != 5'd0) |-> busy[a_rd_addr]);

  a_wb_b_busy: assert property (@(posedge clk) disable iff (!rst_n)
    (b_fire && b_rd_addr != 5'd0) |-> busy[b_rd_addr]);

  a_one_grant: assert property (@(posedge clk) !(a_ready && b_ready));

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed vectors for wb_arbiter with hand-computed
// expectations; inputs change 1ns after the rising edge, checks mid-cycle.
module tb_wb_arbiter;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            a_valid, b_valid;
  logic            a_ready, b_ready;
  logic [4:0]      a_rd_addr, b_rd_addr;
  logic [XLEN-1:0] a_rd_data, b_rd_data;
  logic            rd_write;
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] rd_data;
  logic            issue_set;
  logic [4:0]      issue_rd, chk_rs1, chk_rs2;
  logic            rs1_busy, rs2_busy, any_busy;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready),
    .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
    .b_valid(b_valid), .b_ready(b_ready),
    .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
    .rd_write(rd_write), .rd_addr(rd_addr), .rd_data(rd_data),
    .issue_set(issue_set), .issue_rd(issue_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .any_busy(any_busy)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_valid = 0; b_valid = 0; issue_set = 0;
    a_rd_addr = 0; b_rd_addr = 0; issue_rd = 0;
    a_rd_data = 0; b_rd_data = 0;
  endtask

  initial begin
    idle();
    chk_rs1 = 0; chk_rs2 = 0;
    rst_n = 0;

    for (int i = 0; i < 4; i++) begin
      a_valid = 1'($urandom); b_valid = 1'($urandom);
      a_rd_addr = 5'($urandom); b_rd_addr = 5'($urandom);
      a_rd_data = {$urandom, $urandom}; b_rd_data = {$urandom, $urandom};
      issue_set = 1'($urandom); issue_rd = 5'($urandom);
      #3;
      chk("rst_a_ready", a_ready, 0);
      chk("rst_b_ready", b_ready, 0);
      chk("rst_rd_write", rd_write, 0);
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_any_busy", any_busy, 0);
      tick();
    end
    idle();
    rst_n = 1;
    tick();
    tick();
    chk("post_rst_write", rd_write, 0);
    chk("post_rst_data", rd_data, 0);
    chk("post_rst_busy", any_busy, 0);

    issue_set = 1; issue_rd = 5; chk_rs1 = 5;
    #3 chk("sw_busy_before", rs1_busy, 0);
    tick();
    idle();
    a_valid = 1; a_rd_addr = 5; a_rd_data = 64'hDEAD;
    #3;
    chk("sw_busy_set", rs1_busy, 1);
    chk("sw_a_ready", a_ready, 1);
    tick();
    idle();
    #3;
    chk("sw_rd_write", rd_write, 1);
    chk("sw_rd_addr", rd_addr, 5);
    chk("sw_rd_data", rd_data, 64'hDEAD);
    chk("sw_busy_held", rs1_busy, 1);
    tick();
    chk("sw_busy_clr", rs1_busy, 0);
    chk("sw_write_drop", rd_write, 0);
    chk("sw_rd_hold", rd_data, 64'hDEAD);

    a_valid = 1; b_valid = 1;
    for (int i = 0; i < 7; i++) begin
      #3;
      chk($sformatf("cont_a_%0d", i), a_ready, (i == 4) ? 0 : 1);
      chk($sformatf("cont_b_%0d", i), b_ready, (i == 4) ? 1 : 0);
      tick();
    end
    idle();

    b_valid = 1;
    #3 chk("b_alone", b_ready, 1);
    tick();
    idle();

    a_valid = 1; a_rd_addr = 0; a_rd_data = 64'h1234;
    #3 chk("x0_a_ready", a_ready, 1);
    tick();
    idle();
    #3;
    chk("x0_rd_write", rd_write, 0);
    chk("x0_rd_data", rd_data, 64'h1234);
    chk("x0_busy", any_busy, 0);
    issue_set = 1; issue_rd = 0;
    tick();
    idle();
    chk("x0_issue", any_busy, 0);

    issue_set = 1; issue_rd = 7; chk_rs2 = 7;
    tick();
    idle();
    b_valid = 1; b_rd_addr = 7; b_rd_data = 64'hBEEF;
    #3;
    chk("col_busy", rs2_busy, 1);
    chk("col_b_ready", b_ready, 1);
    tick();
    idle();
    issue_set = 1; issue_rd = 7;
    #3 chk("col_rd_write", rd_write, 1);
    tick();
    idle();
    chk("col_set_wins", rs2_busy, 1);
    chk("col_write_drop", rd_write, 0);
    a_valid = 1; a_rd_addr = 7; a_rd_data = 64'h77;
    tick();
    idle();
    tick();
    chk("col_final_clr", rs2_busy, 0);

    issue_set = 1; issue_rd = 3;
    tick();
    issue_rd = 9; chk_rs1 = 9;
    tick();
    idle();
    a_valid = 1; a_rd_addr = 3; a_rd_data = 64'h55;
    #3 chk("mr_busy9", rs1_busy, 1);
    tick();
    idle();
    chk("mr_pending", rd_write, 1);
    rst_n = 0;
    #1;
    chk("mr_write_drop", rd_write, 0);
    chk("mr_busy_clr", any_busy, 0);
    chk("mr_addr_clr", rd_addr, 0);
    rst_n = 1;
    tick();
    chk("mr_after", rd_write, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
